// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared fetch-stage types and constants; CPU_IF_HALT_EN adds the halted state
package cpu_if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
`ifdef CPU_IF_HALT_EN
    , ST_HALTED
`endif
  } if_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry PC + instruction holding register with load and clear
module if_skid_buf
  import cpu_if_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] ins_in,
  output logic [31:0] pc,
  output logic [31:0] ins
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc  <= 32'h0;
      ins <= NOP;
    end else if (clear) begin
      pc  <= 32'h0;
      ins <= NOP;
    end else if (load) begin
      pc  <= pc_in;
      ins <= ins_in;
    end
  end

endmodule

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - instruction fetch stage with skid buffer and redirect drain; CPU_IF_HALT_EN adds halt
module cpu_if
  import cpu_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
`ifdef CPU_IF_HALT_EN
  input  logic        halt,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_pc,
  output logic [31:0] ins,
  output logic        ins_valid
);

  if_state_t   state;
  logic [31:0] pc_r;
  logic [31:0] drain_addr;
  logic [31:0] buf_pc;
  logic [31:0] buf_ins;
  logic [31:0] target;
  logic        buf_load;
  logic        buf_clear;
  logic        halt_take;

`ifdef CPU_IF_HALT_EN
  logic halt_pend;
  logic halt_drain;
  assign halt_take  = halt && (state == ST_FETCH || state == ST_HOLD);
  assign halt_drain = (halt || halt_pend) && state == ST_DRAIN && imem_ready;
`else
  assign halt_take  = 1'b0;
`endif

  assign target    = word_align(redirect_pc);
  assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
  // DRAIN must keep presenting the abandoned address while pc_r already holds the new target
  assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc_r;

  assign buf_load  = (state == ST_FETCH) && imem_ready && stall && !redirect_en && !halt_take;
  assign buf_clear = redirect_en || halt_take || (state == ST_HOLD && !stall);

  if_skid_buf u_skid (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (buf_load),
    .clear  (buf_clear),
    .pc_in  (pc_r),
    .ins_in (imem_rdata),
    .pc     (buf_pc),
    .ins    (buf_ins)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_FETCH;
      pc_r       <= RESET_PC;
      drain_addr <= RESET_PC;
      current_pc <= 32'h0;
      ins        <= NOP;
      ins_valid  <= 1'b0;
`ifdef CPU_IF_HALT_EN
      halt_pend  <= 1'b0;
`endif
    end else begin
`ifdef CPU_IF_HALT_EN
      halt_pend <= (state == ST_DRAIN) && (halt || halt_pend) && !imem_ready;
`endif
      case (state)
        ST_FETCH: begin
`ifdef CPU_IF_HALT_EN
          if (halt_take) begin
            state      <= ST_HALTED;
            current_pc <= pc_r;
            ins        <= NOP;
            ins_valid  <= 1'b0;
          end else
`endif
          if (redirect_en) begin
            pc_r       <= target;
            current_pc <= target;
            ins        <= NOP;
            ins_valid  <= 1'b0;
            if (!imem_ready) begin
              drain_addr <= pc_r;
              state      <= ST_DRAIN;
            end
          end else if (imem_ready) begin
            pc_r <= pc_r + 32'd4;
            if (stall) begin
              state <= ST_HOLD;
            end else begin
              current_pc <= pc_r;
              ins        <= imem_rdata;
              ins_valid  <= 1'b1;
            end
          end else if (!stall) begin
            current_pc <= pc_r;
            ins        <= NOP;
            ins_valid  <= 1'b0;
          end
        end
        ST_HOLD: begin
`ifdef CPU_IF_HALT_EN
          if (halt_take) begin
            state      <= ST_HALTED;
            current_pc <= pc_r;
            ins        <= NOP;
            ins_valid  <= 1'b0;
          end else
`endif
          if (redirect_en) begin
            pc_r       <= target;
            current_pc <= target;
            ins        <= NOP;
            ins_valid  <= 1'b0;
            state      <= ST_FETCH;
          end else if (!stall) begin
            current_pc <= buf_pc;
            ins        <= buf_ins;
            ins_valid  <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
`ifdef CPU_IF_HALT_EN
          if (halt_drain) begin
            state      <= ST_HALTED;
            ins        <= NOP;
            ins_valid  <= 1'b0;
          end else
`endif
          if (redirect_en) begin
            pc_r       <= target;
            current_pc <= target;
            ins        <= NOP;
            ins_valid  <= 1'b0;
          end else if (imem_ready) begin
            state <= ST_FETCH;
          end
        end
`ifdef CPU_IF_HALT_EN
        ST_HALTED: begin
          ins       <= NOP;
          ins_valid <= 1'b0;
        end
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/cpu_if.md
CPU_IF -- requirements
Module: cpu_if

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 clr_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  from hazard unit; 1 = ID latch must not accept a new instruction.
REQ-005 redirect_en  in  1  from EX; 1 = branch/jump taken, fetch resumes at redirect_pc.
REQ-006 redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
REQ-007 imem_req  out  1  instruction-memory request, held until imem_ready.
REQ-008 imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-009 imem_ready  in  1  1 = imem_rdata valid this cycle; request completes.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 current_pc  out  32  registered PC of ins, to ID stage.
REQ-012 ins  out  32  registered instruction to ID; 32'h00000000 (NOP) when no valid instruction.
REQ-013 ins_valid  out  1  1 = ins/current_pc carry a real fetched instruction.

Function
REQ-014 Internal state: pc_r (next fetch address), FSM {FETCH, HOLD, DRAIN}, 1-entry skid buffer {buf_pc, buf_ins}.
REQ-015 FETCH: imem_req=1, imem_addr=pc_r.
REQ-016 FETCH, imem_ready=1, stall=0: outputs <= {pc_r, imem_rdata, valid=1}; pc_r <= pc_r+4; stay FETCH; one instruction per cycle at zero-wait memory.
REQ-017 FETCH, imem_ready=1, stall=1: outputs hold; skid buffer <= {pc_r, imem_rdata}; pc_r <= pc_r+4; go HOLD.
REQ-018 FETCH, imem_ready=0: stall=0 -> ins<=0, ins_valid<=0, current_pc<=pc_r (bubble); stall=1 -> outputs hold.
REQ-019 HOLD: imem_req=0; stall=1 -> all hold; stall=0 -> outputs <= {buf_pc, buf_ins, valid=1}, go FETCH.
REQ-020 redirect_en=1 has priority over stall and memory completion: pc_r <= redirect_pc; outputs <= bubble (ins=0, valid=0, current_pc=redirect_pc); skid buffer discarded.
REQ-021 Redirect in FETCH with imem_ready=0: go DRAIN; DRAIN keeps imem_req=1 and imem_addr at the abandoned address until imem_ready, discards that data, then goes FETCH at the new pc_r.
REQ-022 Redirect in FETCH with imem_ready=1, or in HOLD: returned/buffered data discarded; go FETCH.
REQ-023 Redirect in DRAIN: pc_r updated to newest target; stay DRAIN.
REQ-024 pc_r arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 with no flag.
REQ-025 No combinational path from stall/redirect_en to imem_addr except through pc_r/FSM registers.

Reset
REQ-026 clr_n=0 asynchronously: pc_r=RESET_PC, FSM=FETCH, current_pc=0, ins=0, ins_valid=0, skid buffer cleared.
REQ-027 Reset mid-request abandons it; after release the first request is RESET_PC.

Configuration
REQ-028 Macro CPU_IF_HALT_EN: when defined, input port halt (1 bit) exists and FSM gains state HALTED.
REQ-029 With CPU_IF_HALT_EN: halt=1 in FETCH/HOLD -> HALTED (from DRAIN after the drain completes); HALTED drives imem_req=0 and bubble outputs; only clr_n exits; halt outranks redirect_en.
REQ-030 Without CPU_IF_HALT_EN: no halt port, no HALTED state, behaviour per REQ-014..027.

Structure
REQ-031 FSM state enum, RESET_PC default and NOP encoding (32'h00000000) live in the shared CPU package/defines.
REQ-032 One sub-module, if_skid_buf (1-entry PC+instruction holding register with load/clear), instantiated in cpu_if.

Verification
REQ-033 Reset release, imem_ready tied 1, stall=0 -> imem_addr 0x3000,0x3004,0x3008; ins_valid=1 from second cycle with matching current_pc.
REQ-034 stall=1 for 3 cycles with ready=1 -> one fetch into skid buffer, outputs frozen, imem_req=0; stall drop -> buffered PC 0x3004 presented next cycle, no loss/duplication.
REQ-035 imem_ready low 2 cycles, redirect_en=1 to 0x4000 on first -> imem_addr stays on old address until ready, data discarded, next request 0x4000, ins=0 valid=0 meanwhile.
REQ-036 redirect_en and stall=1 same cycle -> bubble output, next request redirect_pc.
REQ-037 redirect_pc=0x4002 -> fetch at 0x4000; pc_r=0xFFFFFFFC then ready -> next fetch 0x0.
REQ-038 CPU_IF_HALT_EN defined, halt pulse during redirect -> HALTED, imem_req=0 indefinitely; clr_n pulse -> fetch resumes at 0x3000.
